keystream_quality_ctrl: RTL and testbench



---
 rtl/keystream_quality_ctrl_if.sv | 15 +
 rtl/keystream_quality_ctrl.sv | 120 ++++++++++++
 tb/tb_keystream_quality_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/keystream_quality_ctrl_if.sv
// Keystream link between the chaos generator and the quality controller.
//   ks_valid : generator has a byte on ks_data
//   ks_data  : keystream byte
//   ks_ready : controller accepts the byte this cycle
//   reseed   : one-cycle request for the generator to reseed
// master = generator side, slave = controller side.
interface keystream_quality_ctrl_if;
  logic       ks_valid;
  logic [7:0] ks_data;
  logic       ks_ready;
  logic       reseed;

  modport master (output ks_valid, output ks_data, input ks_ready, input reseed);
  modport slave  (input ks_valid, input ks_data, output ks_ready, output reseed);
endinterface

// File: rtl/keystream_quality_ctrl.sv
// Per-frame keystream quality check. On i_start, collects WINDOW keystream
// bytes, counts distinct values with a 256-bit occupancy bitmap and compares
// against MIN_DISTINCT. Failing windows trigger a generator reseed and a
// fresh window, up to MAX_RETRY times. Final result is held in DONE until
// i_ack.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   i_start          : begin a check (IDLE only)
//   i_ack            : consumer acknowledges result (DONE only)
//   ks               : keystream handshake + reseed request (slave side)
//   o_busy           : not IDLE
//   o_done / o_pass  : result valid / result
//   o_distinct_cnt   : distinct byte values in last/current window
//   o_retry_cnt      : reseeds issued in current check
module keystream_quality_ctrl #(
  parameter int WINDOW       = 256,
  parameter int MIN_DISTINCT = 160,
  parameter int MAX_RETRY    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic                          i_ack,
  keystream_quality_ctrl_if.slave       ks,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_pass,
  output logic [8:0]                    o_distinct_cnt,
  output logic [3:0]                    o_retry_cnt
);

  localparam logic [8:0] LAST_IDX = 9'(WINDOW - 1);
  localparam logic [8:0] MIN_D    = 9'(MIN_DISTINCT);
  localparam logic [3:0] MAX_R    = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COLLECT, S_EVAL, S_RESEED, S_DONE
  } state_t;

  state_t       r_state, w_next;
  logic [255:0] r_bitmap;
  logic [8:0]   r_samp;
  logic [8:0]   r_distinct;
  logic [3:0]   r_retry;
  logic         r_ks_ready;
  logic         r_pass;

  logic w_xfer, w_last, w_new, w_pass_ok, w_retry_ok;

  assign w_xfer     = (r_state == S_COLLECT) && r_ks_ready && ks.ks_valid;
  assign w_last     = w_xfer && (r_samp == LAST_IDX);
  assign w_new      = ~r_bitmap[ks.ks_data];
  assign w_pass_ok  = (r_distinct >= MIN_D);
  assign w_retry_ok = (r_retry < MAX_R);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_next = S_CLEAR;
      S_CLEAR:   w_next = S_COLLECT;
      S_COLLECT: if (w_last) w_next = S_EVAL;
      S_EVAL: begin
        if (w_pass_ok)       w_next = S_DONE;
        else if (w_retry_ok) w_next = S_RESEED;
        else                 w_next = S_DONE;
      end
      S_RESEED:  w_next = S_CLEAR;
      S_DONE:    if (i_ack) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bitmap   <= '0;
      r_samp     <= '0;
      r_distinct <= '0;
      r_retry    <= '0;
      r_ks_ready <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      // Registered ready: rises one cycle after COLLECT entry, drops right
      // after the final transfer so no extra byte slips in.
      r_ks_ready <= (r_state == S_COLLECT) && !w_last;
      case (r_state)
        S_IDLE: if (i_start) r_retry <= '0;
        S_CLEAR: begin
          r_bitmap   <= '0;
          r_samp     <= '0;
          r_distinct <= '0;
        end
        S_COLLECT: if (w_xfer) begin
          r_samp <= r_samp + 9'd1;
          if (w_new) begin
            r_bitmap[ks.ks_data] <= 1'b1;
            r_distinct           <= r_distinct + 9'd1;
          end
        end
        S_EVAL:   r_pass  <= w_pass_ok;
        S_RESEED: r_retry <= r_retry + 4'd1;
        S_DONE:   if (i_ack) r_pass <= 1'b0;
        default: ;
      endcase
    end
  end

  assign ks.ks_ready    = r_ks_ready;
  assign ks.reseed      = (r_state == S_RESEED);
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);
  assign o_pass         = r_pass;
  assign o_distinct_cnt = r_distinct;
  assign o_retry_cnt    = r_retry;

endmodule

// File: tb/tb_keystream_quality_ctrl.sv
module tb_keystream_quality_ctrl;
  localparam int W    = 256;
  localparam int MIND = 160;
  localparam int MAXR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ack = 1'b0;
  logic busy, done, pass;
  logic [8:0] dcnt;
  logic [3:0] rcnt;

  keystream_quality_ctrl_if ks();

  keystream_quality_ctrl #(.WINDOW(W), .MIN_DISTINCT(MIND), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_ack(ack), .ks(ks.slave),
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_distinct_cnt(dcnt), .o_retry_cnt(rcnt)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  logic [7:0] stream [1024];

  typedef struct {
    string nm;
    int mode, lim, pct;
    bit poke;
    int exp_pass, exp_dist, exp_retry, exp_lat;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Four windows of source bytes; window w feeds the w-th attempt.
  task automatic build(input int mode, input int lim);
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < W; k++) begin
        int i;
        i = w * W + k;
        case (mode)
          0: stream[i] = 8'(k);
          1: stream[i] = 8'h5A;
          2: stream[i] = (w == 0) ? 8'h00 : 8'(k);
          default: stream[i] = 8'($urandom_range(lim, 0));
        endcase
      end
  endtask

  // Reference: judge successive windows directly from the byte list.
  task automatic model(output int p, output int d, output int r);
    r = 0; p = 0; d = 0;
    for (int w = 0; w < 4; w++) begin
      bit seen [256];
      foreach (seen[j]) seen[j] = 1'b0;
      d = 0;
      for (int k = 0; k < W; k++)
        if (!seen[stream[w*W+k]]) begin seen[stream[w*W+k]] = 1'b1; d++; end
      if (d >= MIND) begin p = 1; return; end
      if (r < MAXR) r++;
      else begin p = 0; return; end
    end
  endtask

  task automatic run_check(input string nm, input int pct, input bit poke,
                           input int ep, input int ed, input int er, input int elat);
    int idx = 0, xfer = 0, nres = 0, rs_at = 0, lat = 0;
    bit got = 0;
    @(negedge clk);
    start = 1'b1;
    ks.ks_valid = 1'b0;
    for (int k = 1; k < 8000; k++) begin
      @(negedge clk);
      start = poke && (k == 10);
      ack   = poke && (k == 10);
      if (done) begin got = 1; lat = k; break; end
      if (ks.reseed) begin nres++; rs_at = k; end
      if (rs_at > 0 && k == rs_at + 2) begin
        chk({nm, ".reseed_clear_dcnt"}, dcnt, 0);
        chk({nm, ".reseed_retry"}, rcnt, nres);
      end
      ks.ks_valid = ($urandom_range(99, 0) < pct);
      ks.ks_data  = stream[(idx < 1024) ? idx : 0];
      if (ks.ks_valid && ks.ks_ready) begin xfer++; idx++; end
    end
    ks.ks_valid = 1'b0;
    start = 1'b0;
    ack = 1'b0;
    chk({nm, ".done_seen"}, int'(got), 1);
    chk({nm, ".pass"}, pass, ep);
    chk({nm, ".distinct"}, dcnt, ed);
    chk({nm, ".retry"}, rcnt, er);
    chk({nm, ".reseed_pulses"}, nres, er);
    chk({nm, ".transfers"}, xfer, (er + 1) * W);
    chk({nm, ".ready_low"}, ks.ks_ready, 0);
    if (elat > 0) chk({nm, ".latency"}, lat, elat);
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({nm, ".start_in_done"}, done, 1);
      chk({nm, ".pass_held"}, pass, ep);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk({nm, ".ack_done"}, done, 0);
    chk({nm, ".ack_busy"}, busy, 0);
    chk({nm, ".ack_pass"}, pass, 0);
  endtask

  vec_t vecs [5];

  initial begin
    int p, d, r, xfer;
    vecs[0] = '{"ramp",           0, 0, 100, 1'b0, 1, 256, 0, 260};
    vecs[1] = '{"const5a",        1, 0, 100, 1'b0, 0,   1, 3,   0};
    vecs[2] = '{"zero_then_ramp", 2, 0, 100, 1'b0, 1, 256, 1,   0};
    vecs[3] = '{"ramp_stall50",   0, 0,  50, 1'b0, 1, 256, 0,   0};
    vecs[4] = '{"ramp_pokes",     0, 0, 100, 1'b1, 1, 256, 0, 260};

    ks.ks_valid = 1'b0;
    ks.ks_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_state", int'({busy, done, pass, ks.ks_ready, ks.reseed, dcnt, rcnt}), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      build(vecs[i].mode, vecs[i].lim);
      run_check(vecs[i].nm, vecs[i].pct, vecs[i].poke,
                vecs[i].exp_pass, vecs[i].exp_dist, vecs[i].exp_retry, vecs[i].exp_lat);
    end

    // Reset in the middle of a window, then a fresh check.
    build(0, 0);
    @(negedge clk);
    start = 1'b1;
    xfer = 0;
    for (int k = 0; k < 200 && xfer < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      ks.ks_valid = 1'b1;
      ks.ks_data  = stream[xfer];
      if (ks.ks_ready) xfer++;
    end
    chk("midreset.bytes_fed", xfer, 40);
    @(negedge clk);
    ks.ks_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset.outputs", int'({busy, done, pass, ks.ks_ready, ks.reseed, dcnt, rcnt}), 0);
    rst_n = 1'b1;
    run_check("after_reset", 100, 1'b0, 1, 256, 0, 260);

    // Random windows judged by the reference model.
    for (int t = 0; t < 6; t++) begin
      build(3, (t % 2) ? 200 : 255);
      model(p, d, r);
      run_check($sformatf("rand%0d", t), $urandom_range(100, 40), 1'b0, p, d, r, 0);
    end

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end
endmodule
